// File: rtl/patch_fetch_ctrl.sv
// Patch fetch controller: issues ROM reads for fetch requests, buffers the
// returned patches in an in-order FIFO and presents them with valid/ready.
module patch_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned PATCH_WIDTH = 320,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   req_valid_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    output logic                   req_ready_o,
    output logic [ADDR_WIDTH-1:0]  patch_addr_o,
    input  logic [PATCH_WIDTH-1:0] patch_rdata_i,
    output logic                   patch_valid_o,
    output logic [PATCH_WIDTH-1:0] patch_o,
    output logic [ADDR_WIDTH-1:0]  patch_tag_o,
    input  logic                   patch_ready_i,
    output logic                   misalign_o,
    output logic                   busy_o
);

    localparam int unsigned IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CRD_W = PTR_W + 1;

    logic [PATCH_WIDTH-1:0] r_data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  r_tag_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic                   r_infl;
    logic [ADDR_WIDTH-1:0]  r_tag_q;
    logic [ADDR_WIDTH-1:0]  r_patch_addr;
    logic                   r_misalign;

    logic [PTR_W-1:0]       w_cnt;
    logic [CRD_W-1:0]       w_credit;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_pop_eff;
    logic                   w_push;
    logic                   w_accept;

    // Occupancy and handshake terms; a flush cycle neither pushes nor pops
    assign w_cnt     = r_wptr - r_rptr;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_pop     = !w_empty && patch_ready_i;
    assign w_pop_eff = w_pop && !flush_i;
    assign w_push    = r_infl && !flush_i;
    assign w_credit  = CRD_W'(w_cnt) + CRD_W'(r_infl) - CRD_W'(w_pop);
    assign w_accept  = req_valid_i && req_ready_o;

    assign req_ready_o   = !flush_i && (w_credit < CRD_W'(FIFO_DEPTH));
    assign patch_valid_o = !w_empty;
    assign patch_o       = r_data_mem[r_rptr[IDX_W-1:0]];
    assign patch_tag_o   = r_tag_mem[r_rptr[IDX_W-1:0]];
    assign patch_addr_o  = r_patch_addr;
    assign misalign_o    = r_misalign;
    assign busy_o        = r_infl || !w_empty;

    // FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop_eff) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero when idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_data_mem[i] <= '0;
                r_tag_mem[i]  <= '0;
            end
        end else if (w_push) begin
            r_data_mem[r_wptr[IDX_W-1:0]] <= patch_rdata_i;
            r_tag_mem[r_wptr[IDX_W-1:0]]  <= r_tag_q;
        end
    end

    // Read issue: word-aligned ROM address, original byte address kept as tag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_infl       <= 1'b0;
            r_tag_q      <= '0;
            r_patch_addr <= '0;
        end else if (flush_i) begin
            r_infl <= 1'b0;
        end else begin
            r_infl <= w_accept;
            if (w_accept) begin
                r_patch_addr <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                r_tag_q      <= req_addr_i;
            end
        end
    end

    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_misalign <= 1'b0;
        end else if (w_accept && (req_addr_i[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    // The credit rule must never allow a push into a full FIFO
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_push && (w_cnt == PTR_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_patch_fetch_ctrl.sv
// Bench for patch_fetch_ctrl: ROM model, queue-based reference, directed and random traffic.
module tb_patch_fetch_ctrl;

    localparam int unsigned AW    = 16;
    localparam int unsigned PW    = 320;
    localparam int unsigned DEPTH = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic          req_ready_o;
    logic [AW-1:0] patch_addr_o;
    logic [PW-1:0] patch_rdata_i = '0;
    logic          patch_valid_o;
    logic [PW-1:0] patch_o;
    logic [AW-1:0] patch_tag_o;
    logic          patch_ready_i = 1'b0;
    logic          misalign_o;
    logic          busy_o;

    patch_fetch_ctrl #(.ADDR_WIDTH(AW), .PATCH_WIDTH(PW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
        .patch_addr_o(patch_addr_o), .patch_rdata_i(patch_rdata_i),
        .patch_valid_o(patch_valid_o), .patch_o(patch_o), .patch_tag_o(patch_tag_o),
        .patch_ready_i(patch_ready_i), .misalign_o(misalign_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM contents: a distinct, index-dependent pattern in every 32-bit lane
    function automatic logic [PW-1:0] rom_word(input logic [AW-3:0] idx);
        logic [PW-1:0] w;
        w = '0;
        for (int k = 0; k < int'(PW / 32); k++) begin
            w[k*32 +: 32] = {2'b00, idx, 16'(k) * 16'h1F3D} ^ 32'hC0DE_5A5A;
        end
        return w;
    endfunction

    // Negedge-read ROM with one-cycle latency
    always @(negedge clk_i) patch_rdata_i <= rom_word(patch_addr_o[AW-1:2]);

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state: queued tags, one possible read in flight
    logic [AW-1:0] q[$];
    bit            m_infl;
    logic [AW-1:0] m_infl_tag;
    logic [AW-1:0] m_paddr;
    bit            m_mis;

    // Observations from the DUT used by directed tests
    logic [AW-1:0] popped[$];
    int            pop_cyc[$];
    int            dut_acc;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_infl = 0;
        m_infl_tag = '0;
        m_paddr = '0;
        m_mis = 0;
    endtask

    // Compare all outputs against the model, then advance the model one cycle
    task automatic check_and_advance();
        bit exp_valid, exp_pop, exp_rdy, acc;
        int occ;
        exp_valid = (q.size() != 0);
        exp_pop   = exp_valid && patch_ready_i;
        occ       = q.size() + int'(m_infl) - int'(exp_pop);
        exp_rdy   = !flush_i && (occ < int'(DEPTH));
        chk("req_ready", PW'(req_ready_o), PW'(exp_rdy));
        chk("patch_valid", PW'(patch_valid_o), PW'(exp_valid));
        chk("busy", PW'(busy_o), PW'(m_infl || exp_valid));
        chk("misalign", PW'(misalign_o), PW'(m_mis));
        chk("patch_addr", PW'(patch_addr_o), PW'(m_paddr));
        if (exp_valid) begin
            chk("patch_tag", PW'(patch_tag_o), PW'(q[0]));
            chk("patch_data", patch_o, rom_word(q[0][AW-1:2]));
        end
        if (req_valid_i && req_ready_o) dut_acc++;
        if (patch_valid_o && patch_ready_i && !flush_i) begin
            popped.push_back(patch_tag_o);
            pop_cyc.push_back(cyc);
        end
        acc = req_valid_i && exp_rdy;
        if (flush_i) begin
            q.delete();
            m_infl = 0;
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (m_infl) q.push_back(m_infl_tag);
            m_infl = acc;
            if (acc) begin
                m_infl_tag = req_addr_i;
                m_paddr    = {req_addr_i[AW-1:2], 2'b00};
                if (req_addr_i[1:0] != 2'b00) m_mis = 1;
            end
        end
    endtask

    // One clock: inputs were driven at posedge+1, check at posedge+2
    task automatic step();
        #1;
        check_and_advance();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [AW-1:0] a, input bit rdy, input bit fl);
        req_valid_i   = v;
        req_addr_i    = a;
        patch_ready_i = rdy;
        flush_i       = fl;
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, 1, 0);
            step();
        end
    endtask

    initial begin
        int addr_n;
        model_reset();
        #3;
        chk("rst_patch_valid", PW'(patch_valid_o), PW'(0));
        chk("rst_busy", PW'(busy_o), PW'(0));
        chk("rst_patch_addr", PW'(patch_addr_o), PW'(0));
        chk("rst_patch_o", patch_o, PW'(0));
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Single aligned request
        drive(1, 16'h0040, 1, 0); step();
        chk("t1_addr", PW'(patch_addr_o), PW'(16'h0040));
        chk("t1_not_yet_valid", PW'(patch_valid_o), PW'(0));
        drive(0, '0, 1, 0); step();
        chk("t1_valid", PW'(patch_valid_o), PW'(1));
        chk("t1_tag", PW'(patch_tag_o), PW'(16'h0040));
        chk("t1_data", patch_o, rom_word(14'h0010));
        drain();

        // Back-to-back requests at full throughput
        popped.delete(); pop_cyc.delete(); dut_acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'(i * 4), 1, 0); step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0); step();
        end
        chk("t2_accepts", PW'(dut_acc), PW'(4));
        chk("t2_pops", PW'(popped.size()), PW'(4));
        if (popped.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_order", PW'(popped[i]), PW'(16'(i * 4)));
            chk("t2_consecutive", PW'(pop_cyc[3] - pop_cyc[0]), PW'(3));
        end
        drain();

        // Backpressure: exactly DEPTH accepts, then resume without loss
        popped.delete(); dut_acc = 0; addr_n = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 16'(16'h0300 + 4 * dut_acc), 0, 0); step();
        end
        chk("t3_accepts", PW'(dut_acc), PW'(DEPTH));
        chk("t3_ready_low", PW'(req_ready_o), PW'(0));
        chk("t3_head_held", PW'(patch_tag_o), PW'(16'h0300));
        for (int i = 0; i < 6; i++) begin
            drive(1, 16'(16'h0300 + 4 * dut_acc), 1, 0); step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, 0); step();
        end
        chk("t3_total_pops", PW'(popped.size()), PW'(dut_acc));
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("t3_order", PW'(popped[i]), PW'(16'(16'h0300 + 4 * i)));
        drain();

        // Flush with one entry queued and one read in flight
        drive(1, 16'h0080, 0, 0); step();
        drive(1, 16'h0100, 0, 0); step();
        drive(0, '0, 0, 1); step();
        chk("t4_valid_after_flush", PW'(patch_valid_o), PW'(0));
        chk("t4_busy_after_flush", PW'(busy_o), PW'(0));
        popped.delete();
        drive(1, 16'h0200, 1, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, 0); step();
        end
        chk("t4_pop_count", PW'(popped.size()), PW'(1));
        if (popped.size() != 0) chk("t4_tag", PW'(popped[0]), PW'(16'h0200));

        // Misaligned request
        drive(1, 16'h0046, 0, 0); step();
        chk("t5_misalign", PW'(misalign_o), PW'(1));
        chk("t5_addr", PW'(patch_addr_o), PW'(16'h0044));
        drive(0, '0, 0, 0); step();
        chk("t5_tag", PW'(patch_tag_o), PW'(16'h0046));
        chk("t5_data", patch_o, rom_word(14'h0011));
        drive(0, '0, 0, 1); step();
        chk("t5_sticky_flush", PW'(misalign_o), PW'(1));

        // Asynchronous reset with the FIFO full
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'(16'h0500 + 4 * i), 0, 0); step();
        end
        drive(0, '0, 0, 0); step();
        step();
        chk("t6_full_before_rst", PW'(patch_valid_o), PW'(1));
        #3 rst_ni = 1'b0;
        #1;
        chk("t6_valid", PW'(patch_valid_o), PW'(0));
        chk("t6_busy", PW'(busy_o), PW'(0));
        chk("t6_misalign", PW'(misalign_o), PW'(0));
        chk("t6_addr", PW'(patch_addr_o), PW'(0));
        chk("t6_tag", PW'(patch_tag_o), PW'(0));
        chk("t6_data", patch_o, PW'(0));
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        drive(1, 16'h0040, 1, 0); step();
        chk("t6_re_addr", PW'(patch_addr_o), PW'(16'h0040));
        drive(0, '0, 1, 0); step();
        chk("t6_re_tag", PW'(patch_tag_o), PW'(16'h0040));
        chk("t6_re_data", patch_o, rom_word(14'h0010));
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 70), 16'($urandom), ($urandom_range(0, 99) < 65),
                  ($urandom_range(0, 99) < 4));
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
